// File: rtl/alu_issue_stage.sv
// Execute-issue stage feeding main_alu: operand select, opsel encode, RAW hazard
// stall/forward against the two in-flight slots, and rd delay for writeback.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_class,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7b5,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_aluout,
    output logic [31:0] o_op1,
    output logic [31:0] o_op2,
    output logic [3:0]  o_opsel,
    output logic        o_issue_valid,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic [15:0] o_stall_count
);

    typedef enum logic [1:0] {
        CLS_OP    = 2'd0,
        CLS_OPIMM = 2'd1,
        CLS_LUI   = 2'd2,
        CLS_AUIPC = 2'd3
    } cls_e;

    cls_e        cls;
    logic        d1_valid, d2_valid;
    logic [4:0]  d1_rd, d2_rd;
    logic        use_rs1, use_rs2;
    logic        d1_hit1, d1_hit2, d2_hit1, d2_hit2;
    logic        stall, accept;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] next_op1, next_op2;
    logic [3:0]  next_opsel;

    assign cls     = cls_e'(i_class);
    assign use_rs1 = (cls == CLS_OP) || (cls == CLS_OPIMM);
    assign use_rs2 = (cls == CLS_OP);

    // A slot with rd=0 never matches, so x0 sources can never hazard.
    assign d1_hit1 = use_rs1 && d1_valid && (d1_rd != '0) && (i_rs1 == d1_rd);
    assign d1_hit2 = use_rs2 && d1_valid && (d1_rd != '0) && (i_rs2 == d1_rd);
    assign d2_hit1 = use_rs1 && d2_valid && (d2_rd != '0) && (i_rs1 == d2_rd);
    assign d2_hit2 = use_rs2 && d2_valid && (d2_rd != '0) && (i_rs2 == d2_rd);

    assign stall   = d1_hit1 || d1_hit2;
    assign o_ready = !rst && !stall;
    assign accept  = i_valid && o_ready;

    assign rs1_val = (i_rs1 == '0) ? '0 : (d2_hit1 ? i_aluout : i_rs1_data);
    assign rs2_val = (i_rs2 == '0) ? '0 : (d2_hit2 ? i_aluout : i_rs2_data);

    always_comb begin
        next_op1   = '0;
        next_op2   = i_imm;
        next_opsel = '0;
        case (cls)
            CLS_OP: begin
                next_op1   = rs1_val;
                next_op2   = rs2_val;
                next_opsel = {i_funct7b5, i_funct3};
            end
            CLS_OPIMM: begin
                next_op1   = rs1_val;
                next_opsel = {(i_funct3 == 3'b101) && i_funct7b5, i_funct3};
            end
            CLS_LUI:   next_op1 = '0;
            CLS_AUIPC: next_op1 = i_pc;
            default:   next_op1 = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_op1         <= '0;
            o_op2         <= '0;
            o_opsel       <= '0;
            o_issue_valid <= 1'b0;
            d1_valid      <= 1'b0;
            d1_rd         <= '0;
            d2_valid      <= 1'b0;
            d2_rd         <= '0;
            o_stall_count <= '0;
        end else begin
            d2_valid      <= d1_valid;
            d2_rd         <= d1_rd;
            o_issue_valid <= accept;
            d1_valid      <= accept;
            if (accept) begin
                o_op1   <= next_op1;
                o_op2   <= next_op2;
                o_opsel <= next_opsel;
                d1_rd   <= i_rd;
            end
            if (stall && (o_stall_count != '1))
                o_stall_count <= o_stall_count + 16'd1;
        end
    end

    assign o_wb_valid = d2_valid && (d2_rd != '0);
    assign o_wb_rd    = d2_rd;
    assign o_wb_data  = i_aluout;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue stage directly upstream of `main_alu` in the funRV32 core. It accepts one decoded instruction per cycle and selects the ALU operands: register data, immediate, PC or a forwarded ALU result. It encodes the 4-bit ALU opsel, registers `op1`/`op2`/`opsel` into the ALU, and detects read-after-write hazards against the two instructions in flight. It also delays `rd` so writeback enable and address line up with the ALU's registered result.

## Interface
- No parameters; widths fixed to RV32I.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  decoded instruction present on inputs.
- o_ready  out  1  instruction accepted this edge when i_valid & o_ready.
- i_class  in  2  0=OP (R-type), 1=OPIMM, 2=LUI, 3=AUIPC.
- i_funct3  in  3  RV32I funct3.
- i_funct7b5  in  1  instruction bit 30.
- i_rs1, i_rs2, i_rd  in  5 each  register indices.
- i_rs1_data, i_rs2_data  in  32 each  register file read data, not bypassed internally.
- i_imm  in  32  sign-extended or upper immediate, already formatted by decode.
- i_pc  in  32  instruction address.
- i_aluout  in  32  registered result from main_alu.
- o_op1, o_op2  out  32 each  registered ALU operands.
- o_opsel  out  4  registered ALU operation select.
- o_issue_valid  out  1  o_op1/o_op2/o_opsel hold a real instruction.
- o_wb_valid  out  1  i_aluout this cycle is a result to write back.
- o_wb_rd  out  5  destination for o_wb_valid.
- o_wb_data  out  32  combinational copy of i_aluout.
- o_stall_count  out  16  saturating count of hazard stall cycles.

## Operation
- **Opsel encoding** = {b, funct3}. ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - OP: b = i_funct7b5.
  - OPIMM: b = i_funct7b5 only when funct3=101, else 0.
  - LUI/AUIPC: opsel 0000.
- **Operands:**
  - OP: op1=rs1 value, op2=rs2 value.
  - OPIMM: op1=rs1 value, op2=i_imm.
  - LUI: op1=0, op2=i_imm.
  - AUIPC: op1=i_pc, op2=i_imm.
- **Sources used:** OP uses rs1 and rs2; OPIMM uses rs1; LUI/AUIPC use none. Index 0 never hazards and always reads 0.
- **In-flight tracking:**
  - Slot d1 = {valid, rd} of the instruction issued last edge (now in the issue register).
  - Slot d2 = d1 delayed one edge (its result is now on i_aluout).
  - A slot matches only if valid and rd≠0.
- **Stall:** a used source matching d1 forces o_ready=0. On the next edge a bubble is issued (o_issue_valid=0, d1 valid=0), and o_stall_count increments, saturating at 0xFFFF.
- **Forward:** a used source matching d2 (and not d1) takes i_aluout instead of register data.
- **Priority:** a d1 match wins over a d2 match. When both sources match, each source is resolved independently.
- **Accept:** o_ready = !rst & !stall; o_ready does not depend on i_valid. On accept, operands, opsel and d1 load; o_issue_valid=1.
- **Idle:** with no accept, o_issue_valid=0 and d1 valid=0. o_op1/o_op2/o_opsel hold their previous values.
- **Writeback:** o_wb_valid/o_wb_rd = d2 slot; o_wb_valid=0 when rd=0.

## Timing
- Instruction A accepted at edge E0:
  - C1: o_op*/o_issue_valid present A.
  - E1: the ALU latches A.
  - C2: i_aluout = A's result, o_wb_valid=1, o_wb_rd = A.rd.
  - E2: the register file writes A's result.
  - C3 onward: register file reads return A's result.
- Dependent B offered in C1 → stalled 1 cycle, accepted at E2 with the forwarded value.
- Dependent B offered in C2 → forwarded, zero stall.
- Dependent B offered in C3 or later → register data.
- Issue-to-result latency: 2 edges. Throughput: 1/cycle without hazards.
- **Reset:**
  - Takes effect on the edge where rst=1: all outputs registered 0, d1/d2 invalid, counter 0.
  - o_ready=0 while rst=1.
  - Reset mid-stream discards in-flight instructions; no o_wb_valid follows them.

## Test plan
- **Reset:** hold rst 2 cycles → all outputs 0, o_ready=0. Release → o_ready=1, o_issue_valid=0.
- **Opsel/operand coverage:**
  - OP SUB (funct3 000, b=1) rs1=x1=5, rs2=x2=3 → o_opsel=1000, op1=5, op2=3.
  - OPIMM SRAI (funct3 101, b=1) → 1101.
  - OPIMM ADDI with b=1 → 0000.
  - AUIPC pc=0x100, imm=0x2000 → op1=0x100, op2=0x2000.
- **Back-to-back hazard:**
  - Sequence: ADDI x5,x0,7 then ADD x6,x5,x5 offered the next cycle.
  - Required: one cycle o_ready=0 and a bubble; next issue op1=op2=7 taken from i_aluout=7; o_stall_count=1.
- **Gap-of-one forward:** ADDI x5 then independent instr then ADD x6,x5,x0 → no stall, op1 = i_aluout.
- **x0 and LUI:** ADDI x0,x0,1 then ADD x1,x0,x0 → no stall, op1=0, no o_wb_valid for rd=0. LUI x5 followed immediately by LUI x6 → no stall.
- **Writeback alignment and reset:**
  - 4 independent instructions → o_wb_valid/o_wb_rd appear exactly 2 edges after each accept.
  - Assert rst with 2 in flight → no further o_wb_valid.
